// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer: counter encodings
// and the index/tag split of a fetch address.
package btb_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = CTR_WNT;
  localparam ctr_e CTR_ALLOC = CTR_WT;

  // Word-aligned address: bits [1:0] never take part in index or tag.
  function automatic logic [31:0] btb_index(input logic [31:0] addr,
                                            input int unsigned index_bits);
    return (addr >> 2) & ((32'd1 << index_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] btb_tag(input logic [31:0] addr,
                                          input int unsigned index_bits);
    return addr >> (index_bits + 2);
  endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Combinational next-state function of a 2-bit saturating direction counter.
import btb_pkg::*;

module btb_sat_counter (
  input  ctr_e i_ctr,
  input  logic i_taken,
  output ctr_e o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    case (i_ctr)
      CTR_SNT: o_ctr = i_taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: o_ctr = i_taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  o_ctr = i_taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  o_ctr = i_taken ? CTR_ST  : CTR_WT;
      default: o_ctr = i_ctr;
    endcase
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; zero-latency lookup, one-cycle update.
// Optional BTB_BYPASS_EN forwards a same-cycle matching update to the lookup outputs.
import btb_pkg::*;

module btb_predictor #(
  parameter int INDEX_BITS = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] PC,
  output logic [1:0]  FetchBP,
  output logic [31:0] FetchAddress,
  output logic [31:0] FetchBTBInstruction,
  output logic        FetchHit,
  input  logic        UpdValid,
  input  logic [31:0] UpdAddress,
  input  logic [31:0] UpdTarget,
  input  logic        UpdTaken
);

  localparam int ENTRIES  = 2 ** INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic                  r_valid  [ENTRIES];
  logic [TAG_BITS-1:0]   r_tag    [ENTRIES];
  logic [31:0]           r_target [ENTRIES];
  ctr_e                  r_ctr    [ENTRIES];

  logic [INDEX_BITS-1:0] w_pc_idx;
  logic [TAG_BITS-1:0]   w_pc_tag;
  logic [INDEX_BITS-1:0] w_upd_idx;
  logic [TAG_BITS-1:0]   w_upd_tag;
  logic                  w_upd_hit;
  ctr_e                  w_upd_ctr_next;

  logic                  w_hit;
  ctr_e                  w_ctr;
  logic [31:0]           w_target;

  assign w_pc_idx  = INDEX_BITS'(btb_index(PC, INDEX_BITS));
  assign w_pc_tag  = TAG_BITS'(btb_tag(PC, INDEX_BITS));
  assign w_upd_idx = INDEX_BITS'(btb_index(UpdAddress, INDEX_BITS));
  assign w_upd_tag = TAG_BITS'(btb_tag(UpdAddress, INDEX_BITS));

  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  btb_sat_counter u_sat_counter (
    .i_ctr   (r_ctr[w_upd_idx]),
    .i_taken (UpdTaken),
    .o_ctr   (w_upd_ctr_next)
  );

  // NOTE: the table is plain flops, so every entry may be cleared in the
  // reset branch; a RAM macro could not be reset this way.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_RESET;
      end
    end else if (UpdValid) begin
      if (w_upd_hit) begin
        r_ctr[w_upd_idx] <= w_upd_ctr_next;
        if (UpdTaken) r_target[w_upd_idx] <= UpdTarget;
      end else if (UpdTaken) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= UpdTarget;
        r_ctr[w_upd_idx]    <= CTR_ALLOC;
      end
    end
  end

  always_comb begin
    w_hit    = r_valid[w_pc_idx] && (r_tag[w_pc_idx] == w_pc_tag);
    w_ctr    = r_ctr[w_pc_idx];
    w_target = r_target[w_pc_idx];
`ifdef BTB_BYPASS_EN
    // A matching index and tag means the update sees the same entry as the lookup.
    if (UpdValid && (w_upd_idx == w_pc_idx) && (w_upd_tag == w_pc_tag) &&
        (w_upd_hit || UpdTaken)) begin
      w_hit    = 1'b1;
      w_ctr    = w_upd_hit ? w_upd_ctr_next : CTR_ALLOC;
      w_target = UpdTaken ? UpdTarget : w_target;
    end
`endif
  end

  assign FetchHit            = w_hit;
  assign FetchBP             = w_hit ? w_ctr : CTR_SNT;
  assign FetchBTBInstruction = w_hit ? w_target : 32'd0;
  assign FetchAddress        = (w_hit && w_ctr[1]) ? w_target : (PC + 32'd4);

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor (INDEX_BITS=4); expectations are hand-computed.
module tb_btb_predictor;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] PC;
  logic [1:0]  FetchBP;
  logic [31:0] FetchAddress;
  logic [31:0] FetchBTBInstruction;
  logic        FetchHit;
  logic        UpdValid;
  logic [31:0] UpdAddress;
  logic [31:0] UpdTarget;
  logic        UpdTaken;

  int checks   = 0;
  int failures = 0;

  btb_predictor #(.INDEX_BITS(4)) dut (
    .Clk                 (Clk),
    .Rst                 (Rst),
    .PC                  (PC),
    .FetchBP             (FetchBP),
    .FetchAddress        (FetchAddress),
    .FetchBTBInstruction (FetchBTBInstruction),
    .FetchHit            (FetchHit),
    .UpdValid            (UpdValid),
    .UpdAddress          (UpdAddress),
    .UpdTarget           (UpdTarget),
    .UpdTaken            (UpdTaken)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just past it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Present one update while looking up an unrelated PC (index 0, never written).
  task automatic upd(input logic [31:0] addr, input logic [31:0] tgt, input logic taken);
    PC         = 32'h0000_0000;
    UpdValid   = 1'b1;
    UpdAddress = addr;
    UpdTarget  = tgt;
    UpdTaken   = taken;
    tick();
    UpdValid   = 1'b0;
  endtask

  // Combinational lookup, checked well before the next edge.
  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic [1:0] bp, input logic [31:0] faddr, input logic [31:0] instr);
    PC = pc;
    #2;
    check({tag, ".hit"},   {31'd0, FetchHit}, {31'd0, hit});
    check({tag, ".bp"},    {30'd0, FetchBP},  {30'd0, bp});
    check({tag, ".addr"},  FetchAddress, faddr);
    check({tag, ".instr"}, FetchBTBInstruction, instr);
  endtask

  initial begin
    Rst        = 1'b1;
    PC         = 32'h0;
    UpdValid   = 1'b0;
    UpdAddress = 32'h0;
    UpdTarget  = 32'h0;
    UpdTaken   = 1'b0;
    tick();
    tick();
    Rst = 1'b0;

    look("reset", 32'h0040_0000, 1'b0, 2'b00, 32'h0040_0004, 32'h0);

    upd(32'h0040_0010, 32'h0040_0100, 1'b1);
    look("alloc", 32'h0040_0010, 1'b1, 2'b10, 32'h0040_0100, 32'h0040_0100);

    upd(32'h0040_0010, 32'h0040_0100, 1'b1);
    look("inc_st", 32'h0040_0010, 1'b1, 2'b11, 32'h0040_0100, 32'h0040_0100);
    upd(32'h0040_0010, 32'h0040_0100, 1'b1);
    look("sat_st", 32'h0040_0010, 1'b1, 2'b11, 32'h0040_0100, 32'h0040_0100);

    // Not-taken updates carry a bogus target that must not be stored.
    upd(32'h0040_0010, 32'h0DEA_D000, 1'b0);
    look("dec_wt", 32'h0040_0010, 1'b1, 2'b10, 32'h0040_0100, 32'h0040_0100);
    upd(32'h0040_0010, 32'h0DEA_D000, 1'b0);
    look("dec_wnt", 32'h0040_0010, 1'b1, 2'b01, 32'h0040_0014, 32'h0040_0100);
    upd(32'h0040_0010, 32'h0DEA_D000, 1'b0);
    look("dec_snt", 32'h0040_0010, 1'b1, 2'b00, 32'h0040_0014, 32'h0040_0100);
    upd(32'h0040_0010, 32'h0DEA_D000, 1'b0);
    look("sat_snt", 32'h0040_0010, 1'b1, 2'b00, 32'h0040_0014, 32'h0040_0100);

    // Taken on a hit replaces the target even while the counter stays weak.
    upd(32'h0040_0010, 32'h0040_0200, 1'b1);
    look("retarget", 32'h0040_0010, 1'b1, 2'b01, 32'h0040_0014, 32'h0040_0200);

    upd(32'h0040_0050, 32'h0040_0500, 1'b1);
    look("alias_old", 32'h0040_0010, 1'b0, 2'b00, 32'h0040_0014, 32'h0);
    look("alias_new", 32'h0040_0050, 1'b1, 2'b10, 32'h0040_0500, 32'h0040_0500);

    upd(32'h0040_0020, 32'h0000_1234, 1'b0);
    look("miss_nt", 32'h0040_0020, 1'b0, 2'b00, 32'h0040_0024, 32'h0);

    PC         = 32'h0040_0030;
    UpdValid   = 1'b1;
    UpdAddress = 32'h0040_0030;
    UpdTarget  = 32'h0040_0300;
    UpdTaken   = 1'b1;
`ifdef BTB_BYPASS_EN
    look("same_cyc", 32'h0040_0030, 1'b1, 2'b10, 32'h0040_0300, 32'h0040_0300);
`else
    look("same_cyc", 32'h0040_0030, 1'b0, 2'b00, 32'h0040_0034, 32'h0);
`endif
    tick();
    UpdValid = 1'b0;
    look("after_same", 32'h0040_0030, 1'b1, 2'b10, 32'h0040_0300, 32'h0040_0300);

    // Reset wins over a simultaneous update and clears earlier entries.
    PC         = 32'h0000_0000;
    Rst        = 1'b1;
    UpdValid   = 1'b1;
    UpdAddress = 32'h0040_0040;
    UpdTarget  = 32'h0040_0400;
    UpdTaken   = 1'b1;
    tick();
    Rst      = 1'b0;
    UpdValid = 1'b0;
    look("rst_drop", 32'h0040_0040, 1'b0, 2'b00, 32'h0040_0044, 32'h0);
    look("rst_clr", 32'h0040_0030, 1'b0, 2'b00, 32'h0040_0034, 32'h0);

    // Counter reset value is weakly-not-taken: a not-taken update must not allocate,
    // and a hit-free entry is invisible until allocated at CTR_ALLOC.
    upd(32'h0040_0030, 32'h0040_0700, 1'b1);
    look("realloc", 32'h0040_0030, 1'b1, 2'b10, 32'h0040_0700, 32'h0040_0700);

    look("wrap", 32'hFFFF_FFFC, 1'b0, 2'b00, 32'h0000_0000, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
